// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and
// a variable-latency instruction memory.
//   imem_req   : fetch stage has a request outstanding
//   imem_addr  : request address, held stable until acknowledged
//   imem_ack   : memory completion, imem_rdata valid in the same cycle
//   imem_rdata : fetched instruction word
// Modports: master = fetch stage, slave = memory.
interface if_fetch_stage_if #(
  parameter int ADDR_W  = 12,
  parameter int INSTR_W = 19
);
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage feeding the IF/ID pipeline register.
// Owns the PC, issues one request at a time to the instruction memory and
// presents the fetched word with its PC+1 and a valid flag to IF/ID.
// Ports:
//   clk             : clock, rising edge
//   rst             : synchronous reset, active-low
//   stall           : IF/ID not accepting this cycle
//   branch_taken    : one-cycle redirect pulse from a later stage
//   branch_target   : redirect PC, valid with branch_taken
//   imem            : instruction-memory bus (master side)
//   PR0_valid       : PR0_* hold a live instruction; low = bubble
//   PR0_instruction : instruction to IF/ID
//   PR0_PC_plus1    : address of the fetched instruction + 1
module if_fetch_stage #(
  parameter int              ADDR_W   = 12,
  parameter int              INSTR_W  = 19,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [ADDR_W-1:0]   branch_target,
  if_fetch_stage_if.master    imem,
  output logic                PR0_valid,
  output logic [INSTR_W-1:0]  PR0_instruction,
  output logic [ADDR_W-1:0]   PR0_PC_plus1
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,  // request outstanding
    S_VALID = 2'd1,  // instruction held for IF/ID
    S_DROP  = 2'd2   // redirect pending behind an unacked request
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [ADDR_W-1:0]    target_q, target_d;
  logic                 valid_q, valid_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [ADDR_W-1:0]    pc_plus1_q, pc_plus1_d;
  logic [ADDR_W-1:0]    pc_inc;

  // Wraps modulo 2^ADDR_W by construction of the width.
  assign pc_inc = pc_q + ADDR_W'(1);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    target_d   = target_q;
    valid_d    = valid_q;
    instr_d    = instr_q;
    pc_plus1_d = pc_plus1_q;

    unique case (state_q)
      S_FETCH: begin
        if (imem.imem_ack) begin
          if (branch_taken) begin
            // Returned word belongs to the squashed path.
            pc_d = branch_target;
          end else begin
            instr_d    = imem.imem_rdata;
            pc_plus1_d = pc_inc;
            valid_d    = 1'b1;
            state_d    = S_VALID;
          end
        end else if (branch_taken) begin
          // Address must stay stable until ack, so park the target.
          target_d = branch_target;
          state_d  = S_DROP;
        end
      end
      S_VALID: begin
        // Redirect wins over stall: the held instruction is wrong-path.
        if (branch_taken) begin
          valid_d = 1'b0;
          pc_d    = branch_target;
          state_d = S_FETCH;
        end else if (!stall) begin
          valid_d = 1'b0;
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end
      end
      S_DROP: begin
        if (imem.imem_ack) begin
          pc_d    = branch_taken ? branch_target : target_q;
          state_d = S_FETCH;
        end else if (branch_taken) begin
          target_d = branch_target;
        end
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      target_q   <= '0;
      valid_q    <= 1'b0;
      instr_q    <= '0;
      pc_plus1_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      target_q   <= target_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      pc_plus1_q <= pc_plus1_d;
    end
  end

  // Request drops combinationally under reset so an in-flight fetch is abandoned.
  assign imem.imem_req  = rst && ((state_q == S_FETCH) || (state_q == S_DROP));
  assign imem.imem_addr = pc_q;

  assign PR0_valid       = valid_q;
  assign PR0_instruction = instr_q;
  assign PR0_PC_plus1    = pc_plus1_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;
  localparam int ADDR_W  = 12;
  localparam int INSTR_W = 19;

  logic               clk;
  logic               rst;
  logic               stall;
  logic               branch_taken;
  logic [ADDR_W-1:0]  branch_target;
  logic               PR0_valid;
  logic [INSTR_W-1:0] PR0_instruction;
  logic [ADDR_W-1:0]  PR0_PC_plus1;

  int n_chk;
  int n_err;

  if_fetch_stage_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) imem_bus ();

  if_fetch_stage #(
    .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_PC('0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .imem           (imem_bus.master),
    .PR0_valid      (PR0_valid),
    .PR0_instruction(PR0_instruction),
    .PR0_PC_plus1   (PR0_PC_plus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs for one cycle, then step to just after the rising edge.
  task automatic cyc(input logic ack, input logic [INSTR_W-1:0] rdata,
                     input logic stl, input logic br, input logic [ADDR_W-1:0] tgt);
    imem_bus.imem_ack   = ack;
    imem_bus.imem_rdata = rdata;
    stall               = stl;
    branch_taken        = br;
    branch_target       = tgt;
    @(posedge clk);
    #1;
    imem_bus.imem_ack   = 1'b0;
    branch_taken        = 1'b0;
    stall               = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst = 1'b0;
    stall = 1'b0;
    branch_taken = 1'b0;
    branch_target = '0;
    imem_bus.imem_ack = 1'b0;
    imem_bus.imem_rdata = '0;

    // Reset
    cyc(1'b0, '0, 1'b0, 1'b0, '0);
    cyc(1'b0, '0, 1'b0, 1'b0, '0);
    check("rst_req",   imem_bus.imem_req, 0);
    check("rst_valid", PR0_valid, 0);
    check("rst_instr", PR0_instruction, 0);
    check("rst_pc1",   PR0_PC_plus1, 0);
    rst = 1'b1;
    #1;
    check("rel_req",  imem_bus.imem_req, 1);
    check("rel_addr", imem_bus.imem_addr, 0);

    // Zero-latency memory, three fetches back to back
    cyc(1'b1, 19'h00AB1, 1'b0, 1'b0, '0);
    check("f0_valid", PR0_valid, 1);
    check("f0_instr", PR0_instruction, 32'h00AB1);
    check("f0_pc1",   PR0_PC_plus1, 1);
    check("f0_req",   imem_bus.imem_req, 0);
    cyc(1'b0, '0, 1'b0, 1'b0, '0);
    check("f1_addr",  imem_bus.imem_addr, 1);
    check("f1_bub",   PR0_valid, 0);
    check("f1_stale", PR0_instruction, 32'h00AB1);
    cyc(1'b1, 19'h00AB1, 1'b0, 1'b0, '0);
    check("f1_pc1",   PR0_PC_plus1, 2);
    cyc(1'b0, '0, 1'b0, 1'b0, '0);
    check("f2_addr",  imem_bus.imem_addr, 2);
    cyc(1'b1, 19'h00AB1, 1'b0, 1'b0, '0);
    check("f2_valid", PR0_valid, 1);
    check("f2_pc1",   PR0_PC_plus1, 3);

    // Branch from S_VALID to pc=5, then stall for three cycles
    cyc(1'b0, '0, 1'b0, 1'b1, 12'd5);
    check("br5_valid", PR0_valid, 0);
    check("br5_addr",  imem_bus.imem_addr, 5);
    cyc(1'b1, 19'h12345, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      check("stl_valid", PR0_valid, 1);
      check("stl_instr", PR0_instruction, 32'h12345);
      check("stl_pc1",   PR0_PC_plus1, 6);
      check("stl_req",   imem_bus.imem_req, 0);
      cyc(1'b0, '0, 1'b1, 1'b0, '0);
    end
    check("stl_hold", PR0_valid, 1);
    cyc(1'b0, '0, 1'b0, 1'b0, '0);
    check("stl_next", imem_bus.imem_addr, 6);
    check("stl_req1", imem_bus.imem_req, 1);

    // Branch with ack in S_FETCH: data discarded, redirect to 4
    cyc(1'b1, 19'h7FFFF, 1'b0, 1'b1, 12'd4);
    check("fab_valid", PR0_valid, 0);
    check("fab_addr",  imem_bus.imem_addr, 4);

    // Slow memory: redirect to 0x200 one cycle after the request
    cyc(1'b0, '0, 1'b0, 1'b1, 12'h200);
    check("drp_addr0", imem_bus.imem_addr, 4);
    check("drp_req",   imem_bus.imem_req, 1);
    cyc(1'b0, '0, 1'b0, 1'b0, '0);
    check("drp_addr1", imem_bus.imem_addr, 4);
    cyc(1'b1, 19'h3FFFF, 1'b0, 1'b0, '0);
    check("drp_valid", PR0_valid, 0);
    check("drp_tgt",   imem_bus.imem_addr, 32'h200);

    // Two redirects while dropping: latest wins
    cyc(1'b0, '0, 1'b0, 1'b1, 12'h100);
    cyc(1'b0, '0, 1'b0, 1'b1, 12'h300);
    check("dd_addr", imem_bus.imem_addr, 32'h200);
    cyc(1'b1, 19'h11111, 1'b0, 1'b0, '0);
    check("dd_tgt",   imem_bus.imem_addr, 32'h300);
    check("dd_valid", PR0_valid, 0);

    // Stall and branch together in S_VALID: branch wins
    cyc(1'b1, 19'h22222, 1'b0, 1'b0, '0);
    check("sb_pc1", PR0_PC_plus1, 32'h301);
    cyc(1'b0, '0, 1'b1, 1'b1, 12'h050);
    check("sb_valid", PR0_valid, 0);
    check("sb_addr",  imem_bus.imem_addr, 32'h050);
    check("sb_req",   imem_bus.imem_req, 1);

    // PC wrap at 0xFFF
    cyc(1'b1, '0, 1'b0, 1'b1, 12'hFFF);
    check("wr_addr", imem_bus.imem_addr, 32'hFFF);
    cyc(1'b1, 19'h0ABCD, 1'b0, 1'b0, '0);
    check("wr_pc1",   PR0_PC_plus1, 0);
    check("wr_valid", PR0_valid, 1);
    cyc(1'b0, '0, 1'b0, 1'b0, '0);
    check("wr_next",  imem_bus.imem_addr, 0);

    // Reset mid-request
    cyc(1'b1, '0, 1'b0, 1'b1, 12'h0AA);
    check("mr_addr", imem_bus.imem_addr, 32'h0AA);
    rst = 1'b0;
    #1;
    check("mr_req_drop", imem_bus.imem_req, 0);
    cyc(1'b0, '0, 1'b0, 1'b0, '0);
    cyc(1'b1, 19'h55555, 1'b0, 1'b0, '0);
    check("mr_valid", PR0_valid, 0);
    check("mr_instr", PR0_instruction, 0);
    rst = 1'b1;
    #1;
    check("mr_req",  imem_bus.imem_req, 1);
    check("mr_rpc",  imem_bus.imem_addr, 0);
    cyc(1'b0, '0, 1'b0, 1'b0, '0);
    check("mr_hold", PR0_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the PC and issues requests to a variable-latency instruction memory using a req/ack handshake.
- Presents PR0_instruction / PR0_PC_plus1 with a valid flag to the IF/ID register, honouring hazard-unit stalls and branch redirects from later stages.
- PR0_valid low means the IF/ID register must capture a bubble (NOP).

Parameters:
- ADDR_W, 12, PC / instruction-memory address width (matches `ADDRESS_LEN).
- INSTR_W, 19, instruction width (matches `INSTRUCTION_LEN).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-low.
- stall  input  1  hazard unit: IF/ID not accepting this cycle (IF/ID write_en = ~stall).
- branch_taken  input  1  redirect request from a later stage; one-cycle pulse.
- branch_target  input  ADDR_W  redirect PC, valid when branch_taken=1.
- imem_req  output  1  instruction-memory request.
- imem_addr  output  ADDR_W  request address; stable while imem_req=1 and not acked.
- imem_ack  input  1  memory completion; imem_rdata valid in the same cycle.
- imem_rdata  input  INSTR_W  fetched instruction.
- PR0_valid  output  1  PR0_* hold a live instruction.
- PR0_instruction  output  INSTR_W  instruction to IF/ID.
- PR0_PC_plus1  output  ADDR_W  address of the fetched instruction + 1, to IF/ID.

Behaviour:
- States: S_FETCH (request outstanding), S_VALID (instruction held for IF/ID), S_DROP (redirect pending behind an unacked request).
- Reset (rst=0 at rising edge): pc<=RESET_PC, state<=S_FETCH, PR0_valid<=0, PR0_instruction<=0, PR0_PC_plus1<=0, saved target<=0. imem_req is forced 0 combinationally while rst=0.
- imem_req=1 in S_FETCH and S_DROP. imem_addr=pc in S_FETCH and S_DROP, and equals pc in every state.
- S_FETCH, ack=1, branch_taken=0: PR0_instruction<=imem_rdata, PR0_PC_plus1<=pc+1, PR0_valid<=1, go S_VALID.
  - Latency: ack edge -> PR0_valid high the next cycle.
- S_FETCH, ack=1, branch_taken=1: discard data, pc<=branch_target, stay S_FETCH. The new address is presented the next cycle.
- S_FETCH, ack=0, branch_taken=1: save branch_target, go S_DROP. Address is unchanged until ack.
- S_FETCH, ack=0, branch_taken=0: hold. Stall has no effect in S_FETCH.
- S_VALID, branch_taken=1: priority over stall. PR0_valid<=0, pc<=branch_target, go S_FETCH.
- S_VALID, stall=1: hold all PR0_* and pc unchanged; stay.
- S_VALID, stall=0: IF/ID captures at this edge. PR0_valid<=0, pc<=pc+1, go S_FETCH.
  - Peak throughput: one instruction per 2 cycles plus memory latency. Non-pipelined fetch is by design.
- S_DROP, ack=1: discard data, pc<=saved target (or branch_target if branch_taken=1 the same cycle), go S_FETCH.
- S_DROP, ack=0, branch_taken=1: saved target overwritten; latest redirect wins.
- Arithmetic: pc+1 is modulo 2^ADDR_W. pc=2^ADDR_W-1 gives PR0_PC_plus1=0 and next pc=0.
- PR0_instruction and PR0_PC_plus1 change only on a capture (S_FETCH with ack, no branch) or on reset. They retain stale values while PR0_valid=0.
- Reset mid-request: outstanding request is abandoned and any later ack for it is ignored. After rst returns to 1, the first request is to RESET_PC. The memory must tolerate req deassertion before ack.
- imem_ack outside S_FETCH/S_DROP is ignored.

Test Plan:
- Reset then 0-latency memory (ack the same cycle as req, rdata=0x00AB1 at addr 0): imem_addr sequence 0,1,2 on alternate cycles; PR0_valid pulses carry PR0_PC_plus1=1,2,3; no stalls.
- Stall=1 for 3 cycles while S_VALID holds instruction 0x12345 at pc=5: PR0_instruction=0x12345, PR0_PC_plus1=6, PR0_valid=1 throughout; next fetch addr=6 only after stall drops.
- 3-cycle memory latency, branch_taken=1 with target=0x200 one cycle after req to addr 4: addr stays 4 until ack, that data is never valid, next imem_addr=0x200.
- Two redirects in S_DROP (0x100 then 0x300) before ack: next fetch addr=0x300.
- S_VALID with stall=1 and branch_taken=1 (target 0x050) at the same edge: PR0_valid=0 next cycle, next imem_addr=0x050.
- pc=0xFFF fetch: PR0_PC_plus1=0x000, next imem_addr=0x000. Separately, assert rst=0 mid-request: imem_req drops immediately, PR0_valid=0, first request after release is addr RESET_PC.
